// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
package uart_pkg;

    typedef enum logic {RX_IDLE, RX_RECEIVE} rx_state_t;

    localparam int UART_BITS_PER_FRAME = 10;
    localparam int UART_DFLT_BAUD_DIV  = 2604;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous RX pin, resets to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 LSB-first UART receiver; stop-bit error flag under UART_RX_FRAME_ERR_EN
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_DFLT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frm_err
`endif
);

    localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2);
    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(UART_BITS_PER_FRAME - 1);

    rx_state_t   state, state_nxt;
    logic        rx_s;
    logic [11:0] baud_cnt;
    logic [3:0]  bit_cnt;
    // Bit 0 of the frame (the start bit) simply falls off the low end.
    logic [8:1]  rx_shft;
    logic        start_det, shift, frame_end;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (RX),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        shift     = 1'b0;
        frame_end = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_s) begin
                    start_det = 1'b1;
                    state_nxt = RX_RECEIVE;
                end
            end
            RX_RECEIVE: begin
                if (baud_cnt == 12'd0) begin
                    shift = 1'b1;
                    if (bit_cnt == 4'd0 && rx_s) begin
                        state_nxt = RX_IDLE;
                    end else if (bit_cnt == BIT_LAST) begin
                        frame_end = 1'b1;
                        state_nxt = RX_IDLE;
                    end
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt <= 12'd0;
            bit_cnt  <= 4'd0;
            rx_shft  <= 8'h00;
            rx_data  <= 8'h00;
            rdy      <= 1'b0;
        end else begin
            if (start_det) begin
                baud_cnt <= BAUD_HALF;
                bit_cnt  <= 4'd0;
            end else if (state == RX_RECEIVE) begin
                if (shift) begin
                    rx_shft  <= {rx_s, rx_shft[8:2]};
                    bit_cnt  <= bit_cnt + 4'd1;
                    baud_cnt <= BAUD_LAST;
                end else begin
                    baud_cnt <= baud_cnt - 12'd1;
                end
            end
            // At frame end rx_shft holds d7..d0; rx_s is the stop bit being sampled.
            if (frame_end) rx_data <= rx_shft;
            if (frame_end)                 rdy <= 1'b1;
            else if (clr_rdy || start_det) rdy <= 1'b0;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                    frm_err <= 1'b0;
        else if (frame_end)            frm_err <= ~rx_s;
        else if (clr_rdy || start_det) frm_err <= 1'b0;
    end
`endif

endmodule
